// File: rtl/dual_bus_ram_responder.sv
// Purpose: target side of the ibus/dbus request/ready protocol, serving both initiators from one shared word RAM.
// Latency: a grant in IDLE cycle T gives a ready pulse in cycle T+1+WAIT_STATES, then one IDLE cycle before the next grant.
// Backpressure: requests are held by the initiator until ready; arbitration is round-robin, and a release flag blocks re-service of a request still held.
//
// Ports:
//   i_clock, i_reset                 : rising-edge clock, synchronous active-low reset
//   i_ibus_request/address           : read-only instruction port; o_ibus_ready, o_ibus_rdata answer it
//   i_dbus_request/rw/address/wdata  : read/write data port; o_dbus_ready, o_dbus_rdata answer it
//   o_conflict_count                 : IDLE cycles in which both ports were eligible (wraps)
module dual_bus_ram_responder #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    output logic [31:0] o_dbus_rdata,
    input  logic [31:0] i_dbus_wdata,
    output logic [31:0] o_conflict_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    localparam logic PORT_IBUS = 1'b0;
    localparam logic PORT_DBUS = 1'b1;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [3:0]           wait_cnt;
    logic                 gnt_port;
    logic [ADDR_BITS-1:0] gnt_idx;
    logic                 gnt_rw;
    logic [31:0]          gnt_wdata;
    logic                 last_grant;
    logic                 ibus_rel;
    logic                 dbus_rel;
    logic                 ibus_ready_q;
    logic                 dbus_ready_q;
    logic [31:0]          ibus_rdata_q;
    logic [31:0]          dbus_rdata_q;
    logic [31:0]          conflict_q;

    logic [31:0] mem [0:(1<<ADDR_BITS)-1];

    logic                 ibus_elig;
    logic                 dbus_elig;
    logic                 conflict;
    logic                 arb_dbus;
    logic                 grant;
    logic                 enter_resp;
    logic [ADDR_BITS-1:0] ibus_idx;
    logic [ADDR_BITS-1:0] dbus_idx;
    logic                 acc_port;
    logic [ADDR_BITS-1:0] acc_idx;
    logic                 acc_rw;
    logic [31:0]          acc_wdata;
    logic                 unused_addr_bits;

    // Upper address bits alias onto the RAM; byte-lane bits are ignored.
    assign ibus_idx = i_ibus_address[ADDR_BITS+1:2];
    assign dbus_idx = i_dbus_address[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{i_ibus_address[31:ADDR_BITS+2], i_ibus_address[1:0],
                                i_dbus_address[31:ADDR_BITS+2], i_dbus_address[1:0]};

    assign ibus_elig = i_ibus_request && !ibus_rel;
    assign dbus_elig = i_dbus_request && !dbus_rel;
    assign conflict  = ibus_elig && dbus_elig;
    // On a tie the port that was not served last wins.
    assign arb_dbus  = dbus_elig && (!ibus_elig || (last_grant == PORT_IBUS));
    assign grant     = (state == S_IDLE) && (ibus_elig || dbus_elig);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (grant) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESPOND;
            S_WAIT:    if (wait_cnt == 4'd1) state_nxt = S_RESPOND;
            S_RESPOND: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The RAM access happens on the edge into RESPOND so that ready and rdata
    // appear together as registered outputs. With no wait states that edge is
    // also the grant edge, so the access fields bypass the latch from IDLE.
    always_comb begin
        if (state == S_IDLE) begin
            acc_port  = arb_dbus;
            acc_idx   = arb_dbus ? dbus_idx : ibus_idx;
            acc_rw    = arb_dbus && i_dbus_rw;
            acc_wdata = i_dbus_wdata;
        end else begin
            acc_port  = gnt_port;
            acc_idx   = gnt_idx;
            acc_rw    = gnt_rw;
            acc_wdata = gnt_wdata;
        end
    end

    assign enter_resp = (state_nxt == S_RESPOND);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            gnt_port     <= PORT_IBUS;
            gnt_idx      <= '0;
            gnt_rw       <= 1'b0;
            gnt_wdata    <= 32'd0;
            last_grant   <= PORT_DBUS;
            ibus_rel     <= 1'b0;
            dbus_rel     <= 1'b0;
            ibus_ready_q <= 1'b0;
            dbus_ready_q <= 1'b0;
            ibus_rdata_q <= 32'd0;
            dbus_rdata_q <= 32'd0;
            conflict_q   <= 32'd0;
        end else begin
            state <= state_nxt;

            if (grant) begin
                gnt_port  <= acc_port;
                gnt_idx   <= acc_idx;
                gnt_rw    <= acc_rw;
                gnt_wdata <= acc_wdata;
                wait_cnt  <= WAIT_LOAD;
                if (conflict) conflict_q <= conflict_q + 32'd1;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            ibus_ready_q <= enter_resp && (acc_port == PORT_IBUS);
            dbus_ready_q <= enter_resp && (acc_port == PORT_DBUS);

            if (enter_resp && !acc_rw) begin
                if (acc_port == PORT_IBUS) ibus_rdata_q <= mem[acc_idx];
                else                       dbus_rdata_q <= mem[acc_idx];
            end

            if (state == S_RESPOND) last_grant <= gnt_port;

            // The release flag blocks a request still held after its ready
            // until the initiator drops it for at least one cycle.
            if ((state == S_RESPOND) && (gnt_port == PORT_IBUS)) ibus_rel <= 1'b1;
            else if (!i_ibus_request)                              ibus_rel <= 1'b0;

            if ((state == S_RESPOND) && (gnt_port == PORT_DBUS)) dbus_rel <= 1'b1;
            else if (!i_dbus_request)                              dbus_rel <= 1'b0;
        end
    end

    // Reset gating keeps a transaction aborted by reset from committing.
    always_ff @(posedge i_clock) begin
        if (i_reset && enter_resp && acc_rw) mem[acc_idx] <= acc_wdata;
    end

    assign o_ibus_ready     = ibus_ready_q;
    assign o_dbus_ready     = dbus_ready_q;
    assign o_ibus_rdata     = ibus_rdata_q;
    assign o_dbus_rdata     = dbus_rdata_q;
    assign o_conflict_count = conflict_q;

endmodule

// File: tb/tb_dual_bus_ram_responder.sv
// Purpose: randomized and directed stimulus on three responders (WAIT_STATES 1, 0, 3), checked every cycle against a transaction-timeline model.
// Latency: model schedules each ready at grant cycle + 1 + WAIT_STATES.
// Backpressure: bench initiators hold requests until ready, then for a random extra 0..3 cycles.
module tb_dual_bus_ram_responder;

    localparam int AB = 12;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [2:0]  ireq, dreq, drw, irdy, drdy;
    logic [31:0] iaddr [3];
    logic [31:0] daddr [3];
    logic [31:0] dwdata [3];
    logic [31:0] irdata [3];
    logic [31:0] drdata [3];
    logic [31:0] ccount [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dual_bus_ram_responder #(.ADDR_BITS(AB), .WAIT_STATES(ws_of(g))) u_dut (
            .i_clock          (clk),
            .i_reset          (rst_n[g]),
            .i_ibus_request   (ireq[g]),
            .o_ibus_ready     (irdy[g]),
            .i_ibus_address   (iaddr[g]),
            .o_ibus_rdata     (irdata[g]),
            .i_dbus_rw        (drw[g]),
            .i_dbus_request   (dreq[g]),
            .o_dbus_ready     (drdy[g]),
            .i_dbus_address   (daddr[g]),
            .o_dbus_rdata     (drdata[g]),
            .i_dbus_wdata     (dwdata[g]),
            .o_conflict_count (ccount[g])
        );
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is a single server: an idle cycle picks an eligible port
    // (round-robin on ties) and books its completion 1+WS cycles later; the
    // cycle after a completion is not available for a new booking.
    bit          m_valid [3];
    bit          m_busy  [3];
    int          m_due   [3];
    int          m_port  [3];
    bit          m_rw    [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wd    [3];
    int          m_last  [3];
    bit          m_rel   [3][2];
    logic [31:0] m_cnt   [3];
    logic [31:0] m_rd    [3][2];
    logic [31:0] mm [int];
    int          cyc = 0;

    function automatic int key(input int k, input logic [31:0] a);
        return k * 4096 + int'(a[13:2]);
    endfunction

    task automatic model_step(input int k);
        bit       was_busy, ie, de, req;
        bit [1:0] exp_r;
        int       p, g;
        if (!rst_n[k]) begin
            m_valid[k] = 1; m_busy[k] = 0; m_last[k] = 1; m_cnt[k] = 0;
            m_rel[k][0] = 0; m_rel[k][1] = 0; m_rd[k][0] = 0; m_rd[k][1] = 0;
            return;
        end
        if (!m_valid[k]) return;
        was_busy = m_busy[k];
        exp_r = 2'b00;
        p = -1;
        if (m_busy[k] && cyc == m_due[k]) begin
            p = m_port[k];
            exp_r[p] = 1'b1;
            if (m_rw[k]) mm[key(k, m_addr[k])] = m_wd[k];
            else         m_rd[k][p] = mm[key(k, m_addr[k])];
            m_last[k] = p;
            m_busy[k] = 0;
        end
        chk($sformatf("k%0d c%0d ibus_ready", k, cyc), 32'(irdy[k]), 32'(exp_r[0]));
        chk($sformatf("k%0d c%0d dbus_ready", k, cyc), 32'(drdy[k]), 32'(exp_r[1]));
        chk($sformatf("k%0d c%0d ibus_rdata", k, cyc), irdata[k], m_rd[k][0]);
        chk($sformatf("k%0d c%0d dbus_rdata", k, cyc), drdata[k], m_rd[k][1]);
        chk($sformatf("k%0d c%0d conflicts", k, cyc), ccount[k], m_cnt[k]);
        if (!was_busy) begin
            ie = ireq[k] && !m_rel[k][0];
            de = dreq[k] && !m_rel[k][1];
            if (ie || de) begin
                g = (ie && de) ? 1 - m_last[k] : (de ? 1 : 0);
                if (ie && de) m_cnt[k] = m_cnt[k] + 1;
                m_busy[k] = 1;
                m_due[k]  = cyc + 1 + ws_of(k);
                m_port[k] = g;
                m_addr[k] = (g == 1) ? daddr[k] : iaddr[k];
                m_rw[k]   = (g == 1) && drw[k];
                m_wd[k]   = dwdata[k];
            end
        end
        for (int j = 0; j < 2; j++) begin
            req = (j == 1) ? dreq[k] : ireq[k];
            if (j == p) m_rel[k][j] = 1;
            else if (!req) m_rel[k][j] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
        cyc++;
    end

    // ---------------- stimulus ----------------
    int pool [8] = '{0, 1, 4, 8, 5, 'h3FF, 'hFFF, 'h123};

    function automatic logic [31:0] mk_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[13:2] = idx[11:0];
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on either or both ports; returns the cycle (1-based,
    // counted from the request cycle) at which each ready was seen.
    task automatic run_pair(input int k, input bit ui, input logic [31:0] ia,
                            input bit ud, input bit rw, input logic [31:0] da, input logic [31:0] wd,
                            input int hi, input int hd,
                            output int li, output int ld,
                            output logic [31:0] rdi, output logic [31:0] rdd);
        bit done_i, done_d, fin_i, fin_d;
        int t;
        li = -1; ld = -1; rdi = 'x; rdd = 'x;
        if (ui) begin ireq[k] = 1'b1; iaddr[k] = ia; end
        if (ud) begin dreq[k] = 1'b1; drw[k] = rw; daddr[k] = da; dwdata[k] = wd; end
        done_i = !ui; fin_i = !ui; done_d = !ud; fin_d = !ud;
        t = 0;
        while (!(fin_i && fin_d) && t < 100) begin
            @(negedge clk);
            t++;
            if (!done_i && irdy[k]) begin done_i = 1; li = t; rdi = irdata[k]; end
            if (!done_d && drdy[k]) begin done_d = 1; ld = t; rdd = drdata[k]; end
            tick();
            if (done_i && !fin_i) begin
                if (hi == 0) begin ireq[k] = 1'b0; fin_i = 1; end else hi--;
            end
            if (done_d && !fin_d) begin
                if (hd == 0) begin dreq[k] = 1'b0; fin_d = 1; end else hd--;
            end
        end
        chk($sformatf("k%0d transaction completed", k), 32'(fin_i && fin_d), 32'd1);
        ireq[k] = 1'b0;
        dreq[k] = 1'b0;
        tick();
    endtask

    int          li, ld;
    logic [31:0] rdi, rdd, v;

    initial begin
        rst_n = '0; ireq = '0; dreq = '0; drw = '0;
        for (int k = 0; k < 3; k++) begin iaddr[k] = 0; daddr[k] = 0; dwdata[k] = 0; end
        repeat (3) tick();
        rst_n = '1;
        tick();

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("k%0d reset ibus_rdata", k), irdata[k], 32'd0);
            chk($sformatf("k%0d reset dbus_rdata", k), drdata[k], 32'd0);
            chk($sformatf("k%0d reset conflicts", k), ccount[k], 32'd0);
            chk($sformatf("k%0d reset readies", k), {30'd0, irdy[k], drdy[k]}, 32'd0);
        end

        // Preload every word the bench reads so no read ever sees an unwritten RAM word.
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 8; j++)
                run_pair(k, 0, 0, 1, 1, mk_addr(pool[j]), $urandom, 0, 0, li, ld, rdi, rdd);

        // Write then read back, WAIT_STATES=1.
        run_pair(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, li, ld, rdi, rdd);
        chk("ws1 write latency", ld, 3);
        run_pair(0, 0, 0, 1, 0, 32'h10, 0, 0, 0, li, ld, rdi, rdd);
        chk("ws1 read latency", ld, 3);
        chk("ws1 readback", rdd, 32'hDEADBEEF);

        // Aliasing: bit 14 lies above the RAM index.
        run_pair(0, 0, 0, 1, 1, 32'h4010, 32'h12345678, 0, 0, li, ld, rdi, rdd);
        run_pair(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, li, ld, rdi, rdd);
        chk("alias readback", rdi, 32'h12345678);

        // Conflicts after reset: ibus wins first, then round-robin.
        rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1; tick();
        run_pair(0, 1, 32'h0, 1, 0, 32'h4, 0, 0, 0, li, ld, rdi, rdd);
        chk("conflict1 ibus cycle", li, 3);
        chk("conflict1 dbus cycle", ld, 6);
        chk("conflict1 count", ccount[0], 32'd1);
        run_pair(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, li, ld, rdi, rdd);
        run_pair(0, 1, 32'h0, 1, 0, 32'h4, 0, 0, 0, li, ld, rdi, rdd);
        chk("conflict2 dbus cycle", ld, 3);
        chk("conflict2 ibus cycle", li, 6);
        chk("conflict2 count", ccount[0], 32'd2);

        // Held request: one pulse only, then a fresh pulse after re-assertion.
        run_pair(0, 1, 32'h10, 0, 0, 0, 0, 3, 0, li, ld, rdi, rdd);
        chk("held first latency", li, 3);
        run_pair(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, li, ld, rdi, rdd);
        chk("held reassert latency", li, 3);

        // Reset in the middle of WAIT aborts the write, WAIT_STATES=3.
        run_pair(2, 0, 0, 1, 1, 32'h20, 32'h55555555, 0, 0, li, ld, rdi, rdd);
        dreq[2] = 1'b1; drw[2] = 1'b1; daddr[2] = 32'h20; dwdata[2] = 32'hAAAAAAAA;
        tick(); tick();
        rst_n[2] = 1'b0;
        tick();
        rst_n[2] = 1'b1; dreq[2] = 1'b0;
        tick();
        chk("abort ibus_rdata", irdata[2], 32'd0);
        chk("abort dbus_rdata", drdata[2], 32'd0);
        chk("abort conflicts", ccount[2], 32'd0);
        run_pair(2, 0, 0, 1, 0, 32'h20, 0, 0, 0, li, ld, rdi, rdd);
        chk("abort read latency", ld, 5);
        chk("abort readback", rdd, 32'h55555555);

        // WAIT_STATES=0: write does not disturb the last read data.
        v = mm[key(1, 32'h4)];
        run_pair(1, 0, 0, 1, 0, 32'h4, 0, 0, 0, li, ld, rdi, rdd);
        chk("ws0 read latency", ld, 2);
        chk("ws0 read data", rdd, v);
        run_pair(1, 0, 0, 1, 1, 32'h4, 32'h0BADF00D, 0, 0, li, ld, rdi, rdd);
        chk("ws0 rdata kept after write", drdata[1], v);
        run_pair(1, 1, 32'h4, 0, 0, 0, 0, 0, 0, li, ld, rdi, rdd);
        chk("ws0 ibus latency", li, 2);
        chk("ws0 ibus sees write", rdi, 32'h0BADF00D);

        // Random traffic, checked cycle by cycle by the model.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 150; n++) begin
                bit ui, ud;
                ui = ($urandom_range(0, 3) != 0);
                ud = ($urandom_range(0, 3) != 0);
                if (!ui && !ud) ud = 1;
                repeat ($urandom_range(0, 2)) tick();
                run_pair(k, ui, mk_addr(pool[$urandom_range(0, 7)]),
                         ud, 1'($urandom_range(0, 1)), mk_addr(pool[$urandom_range(0, 7)]), $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 3), li, ld, rdi, rdd);
            end
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dual_bus_ram_responder.md
Name: dual_bus_ram_responder

Overview:
Target-side end of the CPU instruction/data bus request/ready protocol. It answers an ibus (read-only) and a dbus (read/write) initiator from a single shared word-addressed RAM. It serialises the two ports with round-robin arbitration, inserts configurable wait states, and counts arbitration conflicts. It sits directly behind the CPU core's ibus/dbus outputs in single-memory test systems.

Parameters:
ADDR_BITS, 12, RAM depth is 2^ADDR_BITS 32-bit words; word index = address[ADDR_BITS+1:2]; higher address bits ignored (aliasing).
WAIT_STATES, 1, extra cycles between acceptance and ready (0..15).

Ports:
i_clock  in  1  clock; all logic on rising edge
i_reset  in  1  synchronous reset, active low
i_ibus_request  in  1  ibus transaction request, held until ready
o_ibus_ready  out  1  one-cycle pulse; ibus transaction complete
i_ibus_address  in  32  ibus byte address (bits 1:0 ignored)
o_ibus_rdata  out  32  ibus read data, valid from ready pulse
i_dbus_rw  in  1  1 = write, 0 = read
i_dbus_request  in  1  dbus transaction request, held until ready
o_dbus_ready  out  1  one-cycle pulse; dbus transaction complete
i_dbus_address  in  32  dbus byte address (bits 1:0 ignored)
i_dbus_rdata  n/a  (none; port intentionally absent)
o_dbus_rdata  out  32  dbus read data, valid from ready pulse
i_dbus_wdata  in  32  dbus write data
o_conflict_count  out  32  cycles both ports competed in IDLE

Behaviour:
- Reset (i_reset==0 at a rising edge): state IDLE, both ready 0, both rdata 0, o_conflict_count 0, last_grant = dbus (so ibus wins the first conflict), both release flags 0. RAM contents are not cleared.
- Reset mid-transaction aborts the transaction. No ready is issued, and no write is committed.
- Initiator rules: request, address, rw and wdata are stable from request high until the ready pulse.
- A port is eligible when its request is 1 and its release flag is 0.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - If no port is eligible, stay in IDLE.
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port not equal to last_grant, and increment o_conflict_count (wraps at 2^32).
  - On a grant, latch the port id, address, rw and wdata; load wait counter = WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESPOND.
- WAIT: decrement the counter each cycle; go to RESPOND the cycle after it reaches 1.
- RESPOND:
  - RAM access occurs (read captured, or write committed) and the granted port's ready pulses for exactly one cycle.
  - rdata is updated for a read only; a write leaves that port's rdata unchanged.
  - Set the granted port's release flag and last_grant; return to IDLE.
- Latency: grant accepted at IDLE cycle T; ready high in cycle T+1+WAIT_STATES.
  - Back-to-back transactions from different ports cost 1 idle-state cycle between readies.
- Release flag: clears on any cycle its port's request is 0. This prevents re-serving a request still held the cycle after ready.
- rdata holds its value until that port's next read ready.
- ibus and dbus at the same word: they are serialised. A dbus write completed before an ibus grant is visible to that ibus read.
- ibus has no write path; ibus transactions are always reads.
- The RAM may be inferred as block RAM with registered read. The RESPOND timing above is the external contract regardless of implementation.

Test Plan:
- Reset, WAIT_STATES=1: dbus write 0xDEADBEEF to 0x00000010, request held → dbus_ready pulses 2 cycles after the grant cycle, one cycle wide. Then dbus read 0x10 → rdata 0xDEADBEEF on ready.
- Aliasing, ADDR_BITS=12: write 0x12345678 to 0x00004010 → ibus read of 0x00000010 returns 0x12345678.
- Simultaneous requests after reset: ibus read 0x0 and dbus read 0x4 raised same cycle → ibus served first, dbus served next; o_conflict_count=1. Repeat with both again → dbus first (round-robin); count=2.
- Held request: initiator keeps ibus_request high 3 cycles past ready → exactly one ready pulse; new pulse only after request drops and re-asserts.
- Reset mid-WAIT (WAIT_STATES=3) during dbus write of 0xAAAAAAAA to 0x20 over prior 0x55555555 → no ready; subsequent read of 0x20 returns 0x55555555; all outputs 0 after reset.
- WAIT_STATES=0: single read → ready in cycle after grant; dbus write leaves o_dbus_rdata at previous read value.
